matmul_tile_scheduler: RTL

Sequencer that runs one large matrix multiply C = A·B (M×K by K×N, up to 255 per dimension) on the 8×8 `matrix_multiplication` unit, one 8×8 tile at a time. For each output tile it walks the K dimension and drives tile addresses, strides, validity masks and accumulate controls. It handles the `start_reg` / `done_mat_mul` / `clear_done_reg` handshake with the unit. It sits between the host/config register block and the matmul instance.

---
 rtl/matmul_tile_scheduler.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/matmul_tile_scheduler.sv
// Tile sequencer: walks a large C = A*B over the 8x8 matmul unit.
// Optional MATMUL_SCHED_PERF_EN adds busy-cycle and launch counters.
module matmul_tile_scheduler #(
  parameter int ADDR_W   = 11,
  parameter int DIM_W    = 8,
  parameter int STRIDE_W = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                go,
  input  logic [DIM_W-1:0]    dim_m,
  input  logic [DIM_W-1:0]    dim_k,
  input  logic [DIM_W-1:0]    dim_n,
  input  logic [ADDR_W-1:0]   base_a,
  input  logic [ADDR_W-1:0]   base_b,
  input  logic [ADDR_W-1:0]   base_c,
  input  logic [STRIDE_W-1:0] stride_a,
  input  logic [STRIDE_W-1:0] stride_b,
  input  logic [STRIDE_W-1:0] stride_c,
  output logic                busy,
  output logic                job_done,
  output logic                mm_start_reg,
  output logic                mm_clear_done_reg,
  input  logic                mm_done_mat_mul,
  output logic [ADDR_W-1:0]   mm_address_mat_a,
  output logic [ADDR_W-1:0]   mm_address_mat_b,
  output logic [ADDR_W-1:0]   mm_address_mat_c,
  output logic [STRIDE_W-1:0] mm_address_stride_a,
  output logic [STRIDE_W-1:0] mm_address_stride_b,
  output logic [STRIDE_W-1:0] mm_address_stride_c,
  output logic [7:0]          mm_validity_mask_a_rows,
  output logic [7:0]          mm_validity_mask_a_cols_b_rows,
  output logic [7:0]          mm_validity_mask_b_cols,
  output logic                mm_save_output_to_accum,
  output logic                mm_add_accum_to_output
`ifdef MATMUL_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_cycles,
  output logic [15:0]         perf_tiles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CLEAR,
    S_ADVANCE,
    S_FINISH
  } state_t;

  localparam logic [DIM_W-1:0]  D8 = DIM_W'(8);
  localparam logic [ADDR_W-1:0] A8 = ADDR_W'(8);

  state_t state_q, state_d;

  logic [DIM_W-1:0]    k_q, k_d, n_q, n_d;
  logic [DIM_W-1:0]    rm_q, rm_d, rk_q, rk_d;
  logic [DIM_W-1:0]    rn_q, rn_d;
  logic [ADDR_W-1:0]   bb_q, bb_d;
  logic [STRIDE_W-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [STRIDE_W-1:0] sc_q, sc_d;
  logic [ADDR_W-1:0]   arow_q, arow_d, brow_q, brow_d;
  logic [ADDR_W-1:0]   crow_q, crow_d;
  logic [ADDR_W-1:0]   aa_q, aa_d, ab_q, ab_d;
  logic [ADDR_W-1:0]   ac_q, ac_d;
  logic [7:0]          mm_q, mm_d, mk_q, mk_d;
  logic [7:0]          mn_q, mn_d;
  logic                sv_q, sv_d, ad_q, ad_d;
  logic [ADDR_W-1:0]   sa8, sb8, sc8;

  // Remaining-element counters stand in for the tile indices:
  // a tile is the last one along its axis when <= 8 remain.
  function automatic logic [7:0] mask8(
    input logic [DIM_W-1:0] rem
  );
    if (rem > DIM_W'(7)) return 8'hFF;
    return ~(8'hFF << rem[2:0]);
  endfunction

  assign sa8 = ADDR_W'(sa_q) << 3;
  assign sb8 = ADDR_W'(sb_q) << 3;
  assign sc8 = ADDR_W'(sc_q) << 3;

  always_comb begin
    state_d = state_q;
    k_d = k_q;
    n_d = n_q;
    rm_d = rm_q;
    rk_d = rk_q;
    rn_d = rn_q;
    bb_d = bb_q;
    sa_d = sa_q;
    sb_d = sb_q;
    sc_d = sc_q;
    arow_d = arow_q;
    brow_d = brow_q;
    crow_d = crow_q;
    aa_d = aa_q;
    ab_d = ab_q;
    ac_d = ac_q;
    mm_d = mm_q;
    mk_d = mk_q;
    mn_d = mn_q;
    sv_d = sv_q;
    ad_d = ad_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          k_d = dim_k;
          n_d = dim_n;
          bb_d = base_b;
          sa_d = stride_a;
          sb_d = stride_b;
          sc_d = stride_c;
          if (dim_m == '0 || dim_k == '0 ||
              dim_n == '0) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_LAUNCH;
            rm_d = dim_m;
            rk_d = dim_k;
            rn_d = dim_n;
            arow_d = base_a;
            brow_d = base_b;
            crow_d = base_c;
            aa_d = base_a;
            ab_d = base_b;
            ac_d = base_c;
            mm_d = mask8(dim_m);
            mk_d = mask8(dim_k);
            mn_d = mask8(dim_n);
            sv_d = dim_k > D8;
            ad_d = 1'b0;
          end
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (mm_done_mat_mul) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (!mm_done_mat_mul) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        state_d = S_LAUNCH;
        if (rk_q > D8) begin
          rk_d = rk_q - D8;
          aa_d = aa_q + A8;
          ab_d = ab_q + A8;
        end else if (rn_q > D8) begin
          rk_d = k_q;
          rn_d = rn_q - D8;
          brow_d = brow_q + sb8;
          aa_d = arow_q;
          ab_d = brow_d;
          ac_d = ac_q + A8;
        end else if (rm_q > D8) begin
          rk_d = k_q;
          rn_d = n_q;
          rm_d = rm_q - D8;
          arow_d = arow_q + sa8;
          crow_d = crow_q + sc8;
          brow_d = bb_q;
          aa_d = arow_d;
          ab_d = bb_q;
          ac_d = crow_d;
        end else begin
          state_d = S_FINISH;
        end
        mm_d = mask8(rm_d);
        mk_d = mask8(rk_d);
        mn_d = mask8(rn_d);
        sv_d = rk_d > D8;
        ad_d = rk_d != k_q;
      end
      S_FINISH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      k_q <= '0;
      n_q <= '0;
      rm_q <= '0;
      rk_q <= '0;
      rn_q <= '0;
      bb_q <= '0;
      sa_q <= '0;
      sb_q <= '0;
      sc_q <= '0;
      arow_q <= '0;
      brow_q <= '0;
      crow_q <= '0;
      aa_q <= '0;
      ab_q <= '0;
      ac_q <= '0;
      mm_q <= '0;
      mk_q <= '0;
      mn_q <= '0;
      sv_q <= 1'b0;
      ad_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      n_q <= n_d;
      rm_q <= rm_d;
      rk_q <= rk_d;
      rn_q <= rn_d;
      bb_q <= bb_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      sc_q <= sc_d;
      arow_q <= arow_d;
      brow_q <= brow_d;
      crow_q <= crow_d;
      aa_q <= aa_d;
      ab_q <= ab_d;
      ac_q <= ac_d;
      mm_q <= mm_d;
      mk_q <= mk_d;
      mn_q <= mn_d;
      sv_q <= sv_d;
      ad_q <= ad_d;
    end
  end

  assign busy = state_q != S_IDLE;
  assign job_done = state_q == S_FINISH;
  assign mm_start_reg = state_q == S_LAUNCH ||
                        state_q == S_WAIT;
  assign mm_clear_done_reg = state_q == S_CLEAR;
  assign mm_address_mat_a = aa_q;
  assign mm_address_mat_b = ab_q;
  assign mm_address_mat_c = ac_q;
  assign mm_address_stride_a = sa_q;
  assign mm_address_stride_b = sb_q;
  assign mm_address_stride_c = sc_q;
  assign mm_validity_mask_a_rows = mm_q;
  assign mm_validity_mask_a_cols_b_rows = mk_q;
  assign mm_validity_mask_b_cols = mn_q;
  assign mm_save_output_to_accum = sv_q;
  assign mm_add_accum_to_output = ad_q;

`ifdef MATMUL_SCHED_PERF_EN
  logic [31:0] pc_q, pc_d;
  logic [15:0] pt_q, pt_d;
  logic        accept;

  assign accept = state_q == S_IDLE && go;

  always_comb begin
    pc_d = pc_q;
    pt_d = pt_q;
    if (accept) begin
      pc_d = '0;
      pt_d = (state_d == S_LAUNCH) ? 16'd1 : 16'd0;
    end else begin
      if (busy) pc_d = pc_q + 32'd1;
      if (state_q == S_ADVANCE &&
          state_d == S_LAUNCH)
        pt_d = pt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q <= '0;
      pt_q <= '0;
    end else begin
      pc_q <= pc_d;
      pt_q <= pt_d;
    end
  end

  assign perf_cycles = pc_q;
  assign perf_tiles = pt_q;
`endif

endmodule
